// File: rtl/estagio_resultado_ula_if.sv
// Valid/ready result bus between the adder/subtractor and its downstream consumer.
// The master modport drives results in and accepts them out; the slave modport is the stage.
interface estagio_resultado_ula_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH:0]   in_s;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_r;
  logic [3:0]       out_flags;
  logic [CNT_W-1:0] res_count;
  logic             any_borrow;

  modport master (
    output in_valid, in_op, in_a, in_b, in_s, out_ready,
    input  in_ready, out_valid, out_r, out_flags, res_count, any_borrow
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_s, out_ready,
    output in_ready, out_valid, out_r, out_flags, res_count, any_borrow
  );
endinterface

// File: rtl/estagio_resultado_ula.sv
// Registered result/flag stage after the ripple adder/subtractor: derives {V,N,Z,C},
// buffers results in a small FIFO, counts accepted results and keeps a sticky borrow flag.
module estagio_resultado_ula #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  estagio_resultado_ula_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [3:0]       mem_f [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;
  logic [WIDTH-1:0] last_r;
  logic [3:0]       last_f;
  logic [CNT_W-1:0] count;
  logic             borrow_seen;

  logic       push;
  logic       pop;
  logic       empty;
  logic       full;
  logic       a_msb;
  logic       b_msb;
  logic       s_msb;
  logic       flag_v;
  logic       flag_n;
  logic       flag_z;
  logic       flag_c;
  logic [3:0] new_flags;
  logic       unused_bits;

  assign empty = (occ == '0);
  assign full  = (occ == OCC_W'(DEPTH));
  assign push  = bus.in_valid & ~full;
  assign pop   = ~empty & bus.out_ready;

  assign a_msb  = bus.in_a[WIDTH-1];
  assign b_msb  = bus.in_b[WIDTH-1];
  assign s_msb  = bus.in_s[WIDTH-1];
  assign flag_c = bus.in_s[WIDTH];
  assign flag_n = s_msb;
  assign flag_z = (bus.in_s[WIDTH-1:0] == '0);
  // Subtraction overflows when operand signs differ; addition when they match.
  assign flag_v = (bus.in_op ? (a_msb != b_msb) : (a_msb == b_msb)) & (s_msb != a_msb);
  assign new_flags = {flag_v, flag_n, flag_z, flag_c};

  assign unused_bits = ^{bus.in_a[WIDTH-2:0], bus.in_b[WIDTH-2:0]};

  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_r[wr_ptr] <= bus.in_s[WIDTH-1:0];
      mem_f[wr_ptr] <= new_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      last_r      <= '0;
      last_f      <= '0;
      count       <= '0;
      borrow_seen <= 1'b0;
    end else if (clear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      last_r      <= '0;
      last_f      <= '0;
      count       <= '0;
      borrow_seen <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        count  <= count + CNT_W'(1);
        if (bus.in_op && flag_c) borrow_seen <= 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        last_r <= mem_r[rd_ptr];
        last_f <= mem_f[rd_ptr];
      end
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // When empty the outputs keep showing the most recently popped entry.
  assign bus.in_ready   = ~full;
  assign bus.out_valid  = ~empty;
  assign bus.out_r      = empty ? last_r : mem_r[rd_ptr];
  assign bus.out_flags  = empty ? last_f : mem_f[rd_ptr];
  assign bus.res_count  = count;
  assign bus.any_borrow = borrow_seen;
endmodule

// File: tb/tb_estagio_resultado_ula.sv
// Directed checks of the result/flag stage: flag vectors, back-pressure, streaming,
// and flush by reset and by clear.
module tb_estagio_resultado_ula;
  logic clk;
  logic rst_n;
  logic clear;
  int   compared;
  int   mismatched;

  estagio_resultado_ula_if #(.WIDTH(8), .CNT_W(16)) bus ();

  estagio_resultado_ula #(.WIDTH(8), .DEPTH(2), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic op, input logic [7:0] a, input logic [7:0] b, input logic [8:0] s);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_s     = s;
  endtask

  task automatic one_result(input string tag, input logic op, input logic [7:0] a,
                            input logic [7:0] b, input logic [8:0] s,
                            input logic [7:0] exp_r, input logic [3:0] exp_f);
    drive(op, a, b, s);
    tick();
    bus.in_valid = 1'b0;
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_r"}, 32'(bus.out_r), 32'(exp_r));
    check({tag, "_flags"}, 32'(bus.out_flags), 32'(exp_f));
    tick();
    check({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_hold_r"}, 32'(bus.out_r), 32'(exp_r));
  endtask

  task automatic check_flushed(input string tag);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_r"}, 32'(bus.out_r), 32'd0);
    check({tag, "_flags"}, 32'(bus.out_flags), 32'd0);
    check({tag, "_count"}, 32'(bus.res_count), 32'd0);
    check({tag, "_borrow"}, 32'(bus.any_borrow), 32'd0);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    compared     = 0;
    mismatched   = 0;
    rst_n        = 1'b0;
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_op    = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_s     = '0;
    bus.out_ready = 1'b1;
    #2;
    check_flushed("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // flags order {V,N,Z,C}
    one_result("sub_5_3", 1'b1, 8'h05, 8'h03, 9'h002, 8'h02, 4'b0000);
    check("sub_5_3_borrow", 32'(bus.any_borrow), 32'd0);
    one_result("sub_3_5", 1'b1, 8'h03, 8'h05, 9'h1FE, 8'hFE, 4'b0101);
    check("sub_3_5_borrow", 32'(bus.any_borrow), 32'd1);
    one_result("sub_80_1", 1'b1, 8'h80, 8'h01, 9'h07F, 8'h7F, 4'b1000);
    one_result("add_7f_1", 1'b0, 8'h7F, 8'h01, 9'h080, 8'h80, 4'b1100);
    check("count4", 32'(bus.res_count), 32'd4);
    check("borrow_sticky", 32'(bus.any_borrow), 32'd1);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_flushed("clear1");
    one_result("add_ff_1", 1'b0, 8'hFF, 8'h01, 9'h100, 8'h00, 4'b0011);
    check("add_carry_no_borrow", 32'(bus.any_borrow), 32'd0);
    check("count_after_clear", 32'(bus.res_count), 32'd1);

    // back-pressure: fill, hold third, then drain in order
    clear = 1'b1;
    tick();
    clear = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 8'h01, 8'h02, 9'h003);
    tick();
    check("fill1_in_ready", 32'(bus.in_ready), 32'd1);
    drive(1'b0, 8'h10, 8'h20, 9'h030);
    tick();
    check("fill2_in_ready", 32'(bus.in_ready), 32'd0);
    check("fill2_head", 32'(bus.out_r), 32'h03);
    drive(1'b1, 8'h00, 8'h01, 9'h1FF);
    tick();
    check("held_in_ready", 32'(bus.in_ready), 32'd0);
    check("held_count", 32'(bus.res_count), 32'd2);
    check("held_borrow", 32'(bus.any_borrow), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    check("pop1_head", 32'(bus.out_r), 32'h30);
    check("pop1_in_ready", 32'(bus.in_ready), 32'd1);
    check("pop1_count", 32'(bus.res_count), 32'd2);
    tick();
    bus.in_valid = 1'b0;
    check("pop2_head", 32'(bus.out_r), 32'hFF);
    check("pop2_flags", 32'(bus.out_flags), 32'b0101);
    check("pop2_count", 32'(bus.res_count), 32'd3);
    check("pop2_borrow", 32'(bus.any_borrow), 32'd1);
    tick();
    check("drain_valid", 32'(bus.out_valid), 32'd0);
    check("drain_hold", 32'(bus.out_r), 32'hFF);

    // streaming: one result per cycle at occupancy 1
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      drive(1'b0, 8'(i), 8'h00, 9'(i * 3));
      tick();
      check($sformatf("stream%0d_r", i), 32'(bus.out_r), 32'(i * 3));
      check($sformatf("stream%0d_in_ready", i), 32'(bus.in_ready), 32'd1);
      check($sformatf("stream%0d_count", i), 32'(bus.res_count), 32'(i));
    end
    bus.in_valid = 1'b0;
    tick();
    check("stream_done_valid", 32'(bus.out_valid), 32'd0);
    check("stream_done_count", 32'(bus.res_count), 32'd10);

    // reset with FIFO full
    bus.out_ready = 1'b0;
    drive(1'b1, 8'h03, 8'h05, 9'h1FE);
    tick();
    tick();
    check("prerst_full", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check_flushed("rst_mid");
    tick();
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    tick();

    // clear with FIFO full, concurrent push and pop discarded
    drive(1'b1, 8'h03, 8'h05, 9'h1FE);
    tick();
    tick();
    check("preclr_full", 32'(bus.in_ready), 32'd0);
    check("preclr_borrow", 32'(bus.any_borrow), 32'd1);
    bus.out_ready = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    bus.in_valid = 1'b0;
    check_flushed("clr_mid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
